bti_fetch_buf: RTL

Instruction prefetch buffer between the `rv32i` fetch stage and the instruction bus slave (`bti_rom`). It issues sequential word fetches on the bus request channel and keeps up to `DEPTH` requests in flight or buffered. Returned instructions are queued in order and handed to the core through a valid/ready port, each tagged with its PC. A redirect from the core flushes the queue, discards in-flight responses and restarts fetching at the new PC.

---
 rtl/bti_fetch_buf_if.sv | 28 ++
 rtl/bti_fetch_buf.sv | 87 ++++++++
 2 files changed

// File: rtl/bti_fetch_buf_if.sv
// Handshake bundle between the fetch buffer, the core fetch stage and the instruction bus.
// The "master" modport is the fetch buffer itself, which masters the bus request channel.
interface bti_fetch_buf_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          redir_vld;
  logic [AW-1:0] redir_pc;
  logic          ifu_vld;
  logic          ifu_rdy;
  logic [AW-1:0] ifu_pc;
  logic [DW-1:0] ifu_inst;
  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_addr;
  logic          rsp_vld;
  logic [DW-1:0] rsp_data;

  modport master (
    input  redir_vld, redir_pc, ifu_rdy, req_rdy, rsp_vld, rsp_data,
    output ifu_vld, ifu_pc, ifu_inst, req_vld, req_addr
  );

  modport slave (
    output redir_vld, redir_pc, ifu_rdy, req_rdy, rsp_vld, rsp_data,
    input  ifu_vld, ifu_pc, ifu_inst, req_vld, req_addr
  );
endinterface

// File: rtl/bti_fetch_buf.sv
// Instruction prefetch buffer: issues sequential word fetches under a credit limit of DEPTH,
// queues returned words with their PC, and flushes/restarts on a core redirect.
module bti_fetch_buf #(
  parameter int            AW      = 32,
  parameter int            DW      = 32,
  parameter int            DEPTH   = 4,
  parameter logic [AW-1:0] BOOT_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  bti_fetch_buf_if.master    bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ;
  logic [OW-1:0] outst, drop, outst_nxt;
  logic [AW-1:0] fetch_pc, rsp_pc, redir_tgt;
  logic [OW:0]   used;
  logic          run, accept, push, pop;

  // Dropped responses still count in outst, so it may exceed DEPTH after a redirect;
  // the extra bit plus the saturation guard keeps it from wrapping on a slow bus.
  assign used      = {1'b0, OW'(occ)} + {1'b0, outst} - {1'b0, drop};
  assign bus.req_vld  = run && !bus.redir_vld && (used < (OW+1)'(DEPTH)) && (outst != '1);
  assign bus.req_addr = fetch_pc;

  assign accept    = bus.req_vld && bus.req_rdy;
  assign push      = bus.rsp_vld && (drop == '0) && !bus.redir_vld;
  assign pop       = bus.ifu_vld && bus.ifu_rdy && !bus.redir_vld;
  assign outst_nxt = outst + OW'(accept) - OW'(bus.rsp_vld);
  assign redir_tgt = bus.redir_pc & ~AW'(3);

  assign bus.ifu_vld  = (occ != '0);
  assign bus.ifu_pc   = bus.ifu_vld ? mem[rd_ptr].pc   : '0;
  assign bus.ifu_inst = bus.ifu_vld ? mem[rd_ptr].inst : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      fetch_pc <= BOOT_PC;
      rsp_pc   <= BOOT_PC;
      outst    <= '0;
      drop     <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      run   <= 1'b1;
      outst <= outst_nxt;
      if (bus.redir_vld) begin
        // Everything still in flight, including earlier drops, is now stale.
        fetch_pc <= redir_tgt;
        rsp_pc   <= redir_tgt;
        drop     <= outst_nxt;
        occ      <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + AW'(4);
        if (bus.rsp_vld && (drop != '0)) drop <= drop - OW'(1);
        if (push) begin
          rsp_pc <= rsp_pc + AW'(4);
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: queue storage has no reset; ifu_pc/ifu_inst are masked while occ is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: rsp_pc, inst: bus.rsp_data};
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && occ == CW'(DEPTH)));
endmodule
